// File: rtl/jk_mod_counter_if.sv
// Control and status bundle for the modulo-N JK counter.
// The counter takes the slave side; whatever sequences or cascades it takes the master side.
interface jk_mod_counter_if #(
   parameter int WIDTH = 4
);
   logic             enable;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count;
   logic             terminal;
   logic             load_err;

   modport master (
      output enable, up, load, load_value,
      input  count, terminal, load_err
   );

   modport slave (
      input  enable, up, load, load_value,
      output count, terminal, load_err
   );
endinterface

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from JK stages in toggle form.
// Supports parallel load with range rejection and a terminal flag for cascading.
module jk_mod_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic            clock,
   input  logic            reset,
   jk_mod_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [31:0]      MOD_U   = 32'(MODULUS);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] tgl;
   logic [WIDTH-1:0] force_val;
   logic             force_en;
   logic             load_ok;
   logic             at_max;
   logic             at_zero;
   logic             out_of_range;
   logic             lerr_q;

   assign load_ok      = (32'(bus.load_value) < MOD_U);
   assign at_max       = (q == MAX_VAL);
   assign at_zero      = (q == '0);
   assign out_of_range = (32'(q) >= MOD_U);

   // Bit i toggles when every lower bit is 1 (up) or 0 (down): a ripple-free carry chain.
   always_comb begin
      logic run;
      tgl = '0;
      run = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         tgl[i] = run;
         run    = run & (bus.up ? q[i] : ~q[i]);
      end
   end

   // Loads and wraps force a target pattern through J/K; ordinary steps use J=K=toggle.
   always_comb begin
      force_en  = 1'b0;
      force_val = '0;
      j         = '0;
      k         = '0;
      if (bus.load) begin
         force_en  = load_ok;
         force_val = bus.load_value;
      end else if (bus.enable) begin
         if (out_of_range || (bus.up && at_max)) begin
            force_en = 1'b1;
         end else if (!bus.up && at_zero) begin
            force_en  = 1'b1;
            force_val = MAX_VAL;
         end else begin
            j = tgl;
            k = tgl;
         end
      end
      if (force_en) begin
         j = force_val;
         k = ~force_val;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q      <= '0;
         lerr_q <= 1'b0;
      end else begin
         q      <= (j & ~q) | (~k & q);
         lerr_q <= bus.load & ~load_ok;
      end
   end

   assign bus.count    = q;
   assign bus.load_err = lerr_q;
   assign bus.terminal = ~reset & bus.enable & ~bus.load &
                         ((bus.up & at_max) | (~bus.up & at_zero));
endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: decade instance, 3-bit binary instance,
// and a two-stage cascaded decade pair.
module tb_jk_mod_counter;
   typedef struct {
      int         dut;
      int         step;
      logic [3:0] cnt;
      logic       term;
      logic       lerr;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   exp_t sb[$];
   int   checks_total  = 0;
   int   checks_passed = 0;
   int   step_no       = 0;

   always #5 clock = ~clock;

   jk_mod_counter_if #(.WIDTH(4)) m_bus ();
   jk_mod_counter_if #(.WIDTH(3)) b_bus ();
   jk_mod_counter_if #(.WIDTH(4)) lo_bus ();
   jk_mod_counter_if #(.WIDTH(4)) hi_bus ();

   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_main (.clock(clock), .reset(reset), .bus(m_bus.slave));
   jk_mod_counter #(.WIDTH(3), .MODULUS(8))  u_bin  (.clock(clock), .reset(reset), .bus(b_bus.slave));
   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo   (.clock(clock), .reset(reset), .bus(lo_bus.slave));
   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi   (.clock(clock), .reset(reset), .bus(hi_bus.slave));

   assign hi_bus.enable     = lo_bus.terminal;
   assign hi_bus.up         = 1'b1;
   assign hi_bus.load       = 1'b0;
   assign hi_bus.load_value = 4'd0;

   task automatic push(input int dut, input logic [3:0] cnt, input logic term, input logic lerr);
      exp_t e;
      e.dut  = dut;
      e.step = step_no;
      e.cnt  = cnt;
      e.term = term;
      e.lerr = lerr;
      sb.push_back(e);
   endtask

   // Inputs change at negedge; expected values describe the state just after the next posedge
   // with these same inputs still applied.
   task automatic drive(input logic rst, input logic en, input logic dir, input logic ld,
                        input logic [3:0] lv, input logic [3:0] cnt, input logic term,
                        input logic lerr);
      @(negedge clock);
      step_no++;
      reset            = rst;
      m_bus.enable     = en;
      m_bus.up         = dir;
      m_bus.load       = ld;
      m_bus.load_value = lv;
      push(0, cnt, term, lerr);
   endtask

   // Monitor: every output sample after an edge consumes the queued expectations.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         while (sb.size() > 0) begin
            exp_t e;
            logic [3:0] a_cnt;
            logic       a_term;
            logic       a_lerr;
            e = sb.pop_front();
            case (e.dut)
               0:       begin a_cnt = m_bus.count;          a_term = m_bus.terminal;  a_lerr = m_bus.load_err;  end
               1:       begin a_cnt = {1'b0, b_bus.count};  a_term = b_bus.terminal;  a_lerr = b_bus.load_err;  end
               2:       begin a_cnt = lo_bus.count;         a_term = lo_bus.terminal; a_lerr = lo_bus.load_err; end
               default: begin a_cnt = hi_bus.count;         a_term = hi_bus.terminal; a_lerr = hi_bus.load_err; end
            endcase
            checks_total++;
            if (a_cnt === e.cnt && a_term === e.term && a_lerr === e.lerr)
               checks_passed++;
            else
               $display("FAIL step%0d_dut%0d: count=%0d terminal=%b load_err=%b, required count=%0d terminal=%b load_err=%b",
                        e.step, e.dut, a_cnt, a_term, a_lerr, e.cnt, e.term, e.lerr);
         end
      end
   end

   initial begin
      reset             = 1'b1;
      m_bus.enable      = 1'b0;
      m_bus.up          = 1'b1;
      m_bus.load        = 1'b0;
      m_bus.load_value  = 4'd0;
      b_bus.enable      = 1'b0;
      b_bus.up          = 1'b1;
      b_bus.load        = 1'b0;
      b_bus.load_value  = 3'd0;
      lo_bus.enable     = 1'b0;
      lo_bus.up         = 1'b1;
      lo_bus.load       = 1'b0;
      lo_bus.load_value = 4'd0;

      // Reset state; terminal stays low under reset even with down-enable at count 0.
      drive(1, 0, 1, 0, 4'd0, 4'd0, 0, 0);
      drive(1, 1, 0, 0, 4'd0, 4'd0, 0, 0);

      // Up count 12 steps: 1..9,0,1,2 with terminal only at 9.
      for (int i = 1; i <= 12; i++)
         drive(0, 1, 1, 0, 4'd0, 4'(i % 10), (i % 10) == 9, 0);

      // Load 1, then down through 0 and wrap to 9.
      drive(0, 1, 0, 1, 4'd1, 4'd1, 0, 0);
      drive(0, 1, 0, 0, 4'd0, 4'd0, 1, 0);
      drive(0, 1, 0, 0, 4'd0, 4'd9, 0, 0);
      drive(0, 1, 0, 0, 4'd0, 4'd8, 0, 0);
      drive(0, 1, 0, 0, 4'd0, 4'd7, 0, 0);

      // Direction change at 0: arrive at 0 counting up, then switch to down.
      drive(0, 1, 0, 1, 4'd9, 4'd9, 0, 0);
      drive(0, 1, 1, 0, 4'd0, 4'd0, 0, 0);
      drive(0, 1, 0, 0, 4'd0, 4'd9, 0, 0);

      // Loads: accepted, rejected (12 and boundary 10), accepted boundary 9.
      drive(0, 1, 1, 1, 4'd7,  4'd7, 0, 0);
      drive(0, 1, 1, 1, 4'd12, 4'd7, 0, 1);
      drive(0, 0, 1, 0, 4'd0,  4'd7, 0, 0);
      drive(0, 0, 1, 1, 4'd10, 4'd7, 0, 1);
      drive(0, 0, 1, 1, 4'd9,  4'd9, 0, 0);

      // Reset mid-count and during loads.
      drive(0, 0, 1, 1, 4'd5,  4'd5, 0, 0);
      drive(1, 1, 1, 0, 4'd0,  4'd0, 0, 0);
      drive(1, 0, 1, 1, 4'd6,  4'd0, 0, 0);
      drive(1, 0, 1, 1, 4'd12, 4'd0, 0, 0);

      // Hold at 4.
      drive(0, 0, 1, 1, 4'd4, 4'd4, 0, 0);
      for (int i = 0; i < 5; i++)
         drive(0, 0, 1, 0, 4'd0, 4'd4, 0, 0);

      // Load wins over enable at terminal value; rejected load still suppresses counting.
      drive(0, 0, 1, 1, 4'd9,  4'd9, 0, 0);
      drive(0, 1, 1, 1, 4'd12, 4'd9, 0, 1);
      drive(0, 1, 1, 1, 4'd3,  4'd3, 0, 0);
      drive(0, 1, 1, 0, 4'd0,  4'd4, 0, 0);

      // 3-bit binary instance and cascade: fresh reset, then run.
      @(negedge clock);
      step_no++;
      reset        = 1'b1;
      m_bus.enable = 1'b0;
      m_bus.load   = 1'b0;
      @(negedge clock);
      reset         = 1'b0;
      b_bus.enable  = 1'b1;
      lo_bus.enable = 1'b1;
      for (int i = 1; i <= 99; i++) begin
         if (i <= 9)
            push(1, 4'(i % 8), (i % 8) == 7, 0);
         if (i == 10)
            b_bus.enable = 1'b0;
         if (i == 99) begin
            push(2, 4'd9, 1, 0);
            push(3, 4'd9, 1, 0);
         end
         step_no++;
         @(negedge clock);
      end
      lo_bus.enable = 1'b0;

      repeat (3) @(negedge clock);
      if (sb.size() != 0) begin
         checks_total++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
